// File: rtl/output_argmax_reader.sv
// Argmax reader: snapshots the final-layer score vector on a start handshake,
// scans it one neuron per cycle and returns the winning class on a result handshake.
module output_argmax_reader #(
  parameter int NUM_OUTPUTS = 10,
  parameter int DATA_W      = 32,
  parameter int IDX_W       = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] scores [NUM_OUTPUTS],
  input  logic              start_valid,
  output logic              start_ready,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [IDX_W-1:0]  class_idx,
  output logic [DATA_W-1:0] class_score,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_OUTPUTS - 1);
  localparam logic [IDX_W-1:0] ONE  = IDX_W'(1);

  state_t            state;
  logic [DATA_W-1:0] snap [NUM_OUTPUTS];
  logic [DATA_W-1:0] best;
  logic [IDX_W-1:0]  best_idx;
  logic [IDX_W-1:0]  scan_idx;
  logic              accept;
  logic              win;

  assign accept = start_valid && start_ready;
  // Strict compare so ties keep the lower index.
  assign win    = $signed(snap[scan_idx]) > $signed(best);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) snap[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NUM_OUTPUTS; i++) snap[i] <= scores[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_ready  <= 1'b1;
      result_valid <= 1'b0;
      busy         <= 1'b0;
      class_idx    <= '0;
      class_score  <= '0;
      best         <= '0;
      best_idx     <= '0;
      scan_idx     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid) begin
            best        <= scores[0];
            best_idx    <= '0;
            scan_idx    <= ONE;
            start_ready <= 1'b0;
            busy        <= 1'b1;
            if (NUM_OUTPUTS == 1) begin
              state        <= DONE;
              result_valid <= 1'b1;
              class_idx    <= '0;
              class_score  <= scores[0];
            end else begin
              state <= SCAN;
            end
          end
        end
        SCAN: begin
          if (win) begin
            best     <= snap[scan_idx];
            best_idx <= scan_idx;
          end
          scan_idx <= scan_idx + ONE;
          // Last neuron: publish the final winner including this cycle's compare.
          if (scan_idx == LAST) begin
            state        <= DONE;
            result_valid <= 1'b1;
            class_idx    <= win ? scan_idx : best_idx;
            class_score  <= win ? snap[scan_idx] : best;
          end
        end
        DONE: begin
          if (result_ready) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            busy         <= 1'b0;
            start_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_output_argmax_reader.sv
// Scoreboard bench for output_argmax_reader: directed score vectors, decoupled result monitor.
module tb_output_argmax_reader;
  localparam int N  = 10;
  localparam int W  = 32;
  localparam int IW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [W-1:0]  scores [N];
  logic          start_valid = 1'b0;
  logic          start_ready;
  logic          result_valid;
  logic          result_ready = 1'b1;
  logic [IW-1:0] class_idx;
  logic [W-1:0]  class_score;
  logic          busy;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int pushed   = 0;
  int popped   = 0;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [W-1:0]  score;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  output_argmax_reader #(.NUM_OUTPUTS(N), .DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .scores(scores),
    .start_valid(start_valid), .start_ready(start_ready),
    .result_valid(result_valid), .result_ready(result_ready),
    .class_idx(class_idx), .class_score(class_score), .busy(busy)
  );

  task automatic check(input string name, input longint got, input longint exp);
    chk_cnt++;
    if (got == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: a result handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (rst_n && result_valid && result_ready) begin
      if (sb.size() == 0) begin
        chk_cnt++;
        $display("FAIL unexpected_result: idx %0d score %0h with empty queue", class_idx, class_score);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        check("result_idx", class_idx, e.idx);
        check("result_score", class_score, e.score);
      end
    end
  end

  task automatic do_start(input logic [IW-1:0] eidx, input logic [W-1:0] escore,
                          input bit scramble, input string tag);
    int n;
    sb.push_back('{eidx, escore});
    pushed++;
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    check({tag, "_start_ready_low"}, start_ready, 0);
    check({tag, "_busy_high"}, busy, 1);
    n = 0;
    while (!result_valid && n < 30) begin
      if (scramble) begin
        for (int k = 0; k < N; k++) scores[k] = W'($urandom_range(0, 50));
        scores[9] = 32'd1000;
      end
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_latency"}, n, 9);
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, start_ready, 1);
    check({tag, "_valid_dropped"}, result_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit stable;
    int n;
    for (int k = 0; k < N; k++) scores[k] = '0;
    #2;
    check("rst_result_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    #10 rst_n = 1'b1;
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_class_idx", class_idx, 0);
    check("rst_class_score", class_score, 0);

    // Clear maximum
    scores = '{32'd0, 32'd5, 32'd3, 32'd9, 32'd1, 32'd2, 32'd4, 32'd100, 32'd7, 32'd8};
    do_start(4'd7, 32'd100, 1'b0, "max");
    handshake("max");

    // Tie keeps the lower index
    for (int k = 0; k < N; k++) scores[k] = '0;
    scores[2] = 32'h0001_0000;
    scores[5] = 32'h0001_0000;
    do_start(4'd2, 32'h0001_0000, 1'b0, "tie");
    handshake("tie");

    // All negative, with the most negative value at index 0
    for (int k = 0; k < N; k++) scores[k] = W'(-(k + 2));
    scores[4] = 32'hFFFF_FFFF;
    scores[0] = 32'h8000_0000;
    do_start(4'd4, 32'hFFFF_FFFF, 1'b0, "neg");
    handshake("neg");

    // Backpressure with an ignored start pulse in the window
    result_ready = 1'b0;
    scores = '{32'd3, 32'd6, 32'd9, 32'd500, 32'd12, 32'd15, 32'd18, 32'd21, 32'd24, 32'd27};
    do_start(4'd3, 32'd500, 1'b0, "bp");
    stable = 1'b1;
    for (int c = 0; c < 20; c++) begin
      if (c == 5) begin
        scores[0]   = 32'd9999;
        start_valid = 1'b1;
      end
      if (c == 6) start_valid = 1'b0;
      @(posedge clk); #1;
      if (!result_valid || class_idx != 4'd3 || class_score != 32'd500 || start_ready || !busy)
        stable = 1'b0;
    end
    start_valid = 1'b0;
    check("bp_stable", stable, 1);
    handshake("bp");
    check("bp_busy_low", busy, 0);
    check("bp_idx_held", class_idx, 3);
    repeat (3) @(posedge clk);
    #1;
    check("bp_start_not_queued", busy, 0);

    // Scores change every scan cycle; result must come from the snapshot
    scores = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd77, 32'd6, 32'd7, 32'd8, 32'd9};
    do_start(4'd5, 32'd77, 1'b1, "snap");
    handshake("snap");
    check("snap_idx_held", class_idx, 5);

    // Reset mid-scan aborts; a fresh start then runs with full latency
    scores = '{32'd0, 32'd5, 32'd3, 32'd9, 32'd1, 32'd2, 32'd4, 32'd100, 32'd7, 32'd8};
    start_valid = 1'b1;
    @(posedge clk); #1;
    start_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_result_valid", result_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_class_idx", class_idx, 0);
    check("abort_class_score", class_score, 0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_start_ready", start_ready, 1);
    check("abort_no_result", result_valid, 0);
    do_start(4'd7, 32'd100, 1'b0, "after_rst");
    handshake("after_rst");

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("sb_drained", sb.size(), 0);
    check("results_seen", popped, pushed);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
